// File: rtl/jtag_tap_controller_pkg.sv
// Shared definitions for the JTAG TAP controller.
//   tap_state_t : 16-state TAP encoding (standard 1149.1 4-bit values)
//   dr_sel_t    : data register selected by the current instruction
//   Default opcodes, IDCODE value and the BYPASS capture constant.
package jtag_tap_controller_pkg;

    typedef enum logic [3:0] {
        EXIT2_DR         = 4'h0,
        EXIT1_DR         = 4'h1,
        SHIFT_DR         = 4'h2,
        PAUSE_DR         = 4'h3,
        SEL_IR           = 4'h4,
        UPDATE_DR        = 4'h5,
        CAP_DR           = 4'h6,
        SEL_DR           = 4'h7,
        EXIT2_IR         = 4'h8,
        EXIT1_IR         = 4'h9,
        SHIFT_IR         = 4'hA,
        PAUSE_IR         = 4'hB,
        RUN_TEST_IDLE    = 4'hC,
        UPDATE_IR        = 4'hD,
        CAP_IR           = 4'hE,
        TEST_LOGIC_RESET = 4'hF
    } tap_state_t;

    typedef enum logic [1:0] {
        DR_BYPASS = 2'd0,
        DR_IDCODE = 2'd1,
        DR_USER   = 2'd2
    } dr_sel_t;

    localparam logic [3:0]  DEFAULT_IDCODE_INSTR = 4'b0001;
    localparam logic [3:0]  DEFAULT_USER_INSTR   = 4'b0010;
    localparam logic [31:0] DEFAULT_IDCODE_VALUE = 32'h1234_5A5B;
    localparam int          IDCODE_LEN           = 32;
    localparam logic        BYPASS_CAPTURE       = 1'b0;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/jtag_tap_controller_fsm.sv
// TAP state machine: state register plus Tms-driven next-state logic.
//   clk      : TCK-equivalent clock, state advances on rising edge
//   reset    : asynchronous active-high, forces TEST_LOGIC_RESET
//   Tms      : test mode select
//   tapState : current TAP state (tap_state_t encoding)
module jtag_tap_fsm
    import jtag_tap_controller_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       Tms,
    output logic [3:0] tapState
);

    tap_state_t state;
    tap_state_t next_state;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= TEST_LOGIC_RESET;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            TEST_LOGIC_RESET: next_state = Tms ? TEST_LOGIC_RESET : RUN_TEST_IDLE;
            RUN_TEST_IDLE:    next_state = Tms ? SEL_DR   : RUN_TEST_IDLE;
            SEL_DR:           next_state = Tms ? SEL_IR   : CAP_DR;
            CAP_DR:           next_state = Tms ? EXIT1_DR : SHIFT_DR;
            SHIFT_DR:         next_state = Tms ? EXIT1_DR : SHIFT_DR;
            EXIT1_DR:         next_state = Tms ? UPDATE_DR : PAUSE_DR;
            PAUSE_DR:         next_state = Tms ? EXIT2_DR : PAUSE_DR;
            EXIT2_DR:         next_state = Tms ? UPDATE_DR : SHIFT_DR;
            UPDATE_DR:        next_state = Tms ? SEL_DR   : RUN_TEST_IDLE;
            SEL_IR:           next_state = Tms ? TEST_LOGIC_RESET : CAP_IR;
            CAP_IR:           next_state = Tms ? EXIT1_IR : SHIFT_IR;
            SHIFT_IR:         next_state = Tms ? EXIT1_IR : SHIFT_IR;
            EXIT1_IR:         next_state = Tms ? UPDATE_IR : PAUSE_IR;
            PAUSE_IR:         next_state = Tms ? EXIT2_IR : PAUSE_IR;
            EXIT2_IR:         next_state = Tms ? UPDATE_IR : SHIFT_IR;
            UPDATE_IR:        next_state = Tms ? SEL_DR   : RUN_TEST_IDLE;
            default:          next_state = TEST_LOGIC_RESET;
        endcase
    end

    always_comb begin
        tapState = state;
    end

endmodule

// File: rtl/jtag_tap_controller.sv
// JTAG TAP target: instruction register, BYPASS / IDCODE / USER data
// registers and the Tdo output mux.
//   clk           : TCK-equivalent clock
//   reset         : asynchronous active-high reset
//   Tms, Tdi      : JTAG mode select and serial data in
//   Tdo           : serial data out (LSB of active shift register in SHIFT_x)
//   tapState      : current TAP state
//   irValue       : current updated instruction
//   userReg       : USER data register contents
//   updateDrPulse : high during the UPDATE_DR cycle that writes userReg
module jtag_tap_controller
    import jtag_tap_controller_pkg::*;
#(
    parameter int                    IR_WIDTH      = 4,
    parameter int                    USER_DR_WIDTH = 8,
    parameter logic [31:0]           IDCODE_VALUE  = DEFAULT_IDCODE_VALUE,
    parameter logic [IR_WIDTH-1:0]   IDCODE_INSTR  = IR_WIDTH'(DEFAULT_IDCODE_INSTR),
    parameter logic [IR_WIDTH-1:0]   USER_INSTR    = IR_WIDTH'(DEFAULT_USER_INSTR)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     Tms,
    input  logic                     Tdi,
    output logic                     Tdo,
    output logic [3:0]               tapState,
    output logic [IR_WIDTH-1:0]      irValue,
    output logic [USER_DR_WIDTH-1:0] userReg,
    output logic                     updateDrPulse
);

    // One DR shift register shared by all data registers, sized for the longest.
    localparam int DR_W = max_int(IDCODE_LEN, USER_DR_WIDTH);
    localparam logic [IR_WIDTH-1:0] IR_CAPTURE = IR_WIDTH'(2'b01);

    tap_state_t          state;
    dr_sel_t             dr_sel;
    logic [IR_WIDTH-1:0] ir_shift;
    logic [DR_W-1:0]     dr_shift;
    logic [DR_W-1:0]     dr_capture;
    logic [DR_W-1:0]     dr_shifted;

    jtag_tap_fsm u_fsm (
        .clk      (clk),
        .reset    (reset),
        .Tms      (Tms),
        .tapState (tapState)
    );

    assign state = tap_state_t'(tapState);

    always_comb begin
        if (irValue == IDCODE_INSTR) begin
            dr_sel = DR_IDCODE;
        end else if (irValue == USER_INSTR) begin
            dr_sel = DR_USER;
        end else begin
            dr_sel = DR_BYPASS;
        end
    end

    // Tdi is inserted at the top of the selected register's length so that
    // over-long scans stream through with a delay of exactly that length.
    always_comb begin
        dr_capture = DR_W'(BYPASS_CAPTURE);
        dr_shifted = dr_shift >> 1;
        case (dr_sel)
            DR_IDCODE: begin
                dr_capture                 = DR_W'(IDCODE_VALUE);
                dr_shifted[IDCODE_LEN-1]   = Tdi;
            end
            DR_USER: begin
                dr_capture                 = DR_W'(userReg);
                dr_shifted[USER_DR_WIDTH-1] = Tdi;
            end
            default: begin
                dr_capture                 = DR_W'(BYPASS_CAPTURE);
                dr_shifted[0]              = Tdi;
            end
        endcase
    end

    // Shift registers: capture on the edge leaving CAP_x, shift on every edge
    // spent in SHIFT_x; all other states (PAUSE included) hold.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ir_shift <= '0;
            dr_shift <= '0;
        end else begin
            case (state)
                CAP_IR:   ir_shift <= IR_CAPTURE;
                SHIFT_IR: ir_shift <= {Tdi, ir_shift[IR_WIDTH-1:1]};
                CAP_DR:   dr_shift <= dr_capture;
                SHIFT_DR: dr_shift <= dr_shifted;
                default:  ;
            endcase
        end
    end

    // TLR is only entered from TLR or SEL_IR with Tms=1, so those edges
    // restore the IDCODE instruction.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irValue <= IDCODE_INSTR;
        end else if (((state == TEST_LOGIC_RESET) || (state == SEL_IR)) && Tms) begin
            irValue <= IDCODE_INSTR;
        end else if (state == UPDATE_IR) begin
            irValue <= ir_shift;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            userReg <= '0;
        end else if ((state == UPDATE_DR) && (dr_sel == DR_USER)) begin
            userReg <= dr_shift[USER_DR_WIDTH-1:0];
        end
    end

    // Outputs depend only on registered state, never on Tdi/Tms.
    always_comb begin
        updateDrPulse = (state == UPDATE_DR) && (dr_sel == DR_USER);
        case (state)
            SHIFT_IR: Tdo = ir_shift[0];
            SHIFT_DR: Tdo = dr_shift[0];
            default:  Tdo = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_jtag_tap_controller.sv
// Directed testbench for jtag_tap_controller (default parameters).
module tb_jtag_tap_controller;

    logic       clk;
    logic       reset;
    logic       Tms;
    logic       Tdi;
    logic       Tdo;
    logic [3:0] tapState;
    logic [3:0] irValue;
    logic [7:0] userReg;
    logic       updateDrPulse;

    int checks = 0;
    int errors = 0;

    jtag_tap_controller dut (
        .clk           (clk),
        .reset         (reset),
        .Tms           (Tms),
        .Tdi           (Tdi),
        .Tdo           (Tdo),
        .tapState      (tapState),
        .irValue       (irValue),
        .userReg       (userReg),
        .updateDrPulse (updateDrPulse)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Apply Tms/Tdi, take one rising edge, settle 1 time unit after it.
    task automatic step(input logic tms, input logic tdi);
        Tms = tms;
        Tdi = tdi;
        @(posedge clk);
        #1;
    endtask

    // From RUN_TEST_IDLE: full IR scan, back to RUN_TEST_IDLE.
    task automatic ir_scan(input logic [3:0] data, output logic [3:0] tdo_bits);
        tdo_bits = '0;
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tdo_bits[i] = Tdo;
            step(i == 3, data[i]);
        end
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
    endtask

    // From RUN_TEST_IDLE: n-bit DR scan, back to RUN_TEST_IDLE.
    task automatic dr_scan(input logic [31:0] data, input int n,
                           output logic [31:0] tdo_bits, output logic pulse);
        tdo_bits = '0;
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        for (int i = 0; i < n; i++) begin
            tdo_bits[i] = Tdo;
            step(i == n - 1, data[i]);
        end
        step(1'b1, 1'b0);
        pulse = updateDrPulse;
        step(1'b0, 1'b0);
    endtask

    logic [31:0] got;
    logic [3:0]  got_ir;
    logic        pulse;

    initial begin
        reset = 1'b1;
        Tms   = 1'b1;
        Tdi   = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("reset_state", 32'(tapState), 32'hF);
        check("reset_ir", 32'(irValue), 32'h1);
        check("reset_user", 32'(userReg), 32'h0);
        check("reset_tdo", 32'(Tdo), 32'h0);
        check("reset_pulse", 32'(updateDrPulse), 32'h0);
        reset = 1'b0;

        // Walk to SHIFT_DR then five Tms=1 edges.
        step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        check("walk_shift_dr", 32'(tapState), 32'h2);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
        check("tlr_from_shift_dr", 32'(tapState), 32'hF);
        check("tlr_ir", 32'(irValue), 32'h1);
        check("tlr_tdo", 32'(Tdo), 32'h0);

        // Walk to PAUSE_IR then five Tms=1 edges.
        step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        check("walk_pause_ir", 32'(tapState), 32'hB);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
        check("tlr_from_pause_ir", 32'(tapState), 32'hF);
        step(1'b0, 1'b0);
        check("rti", 32'(tapState), 32'hC);

        // IDCODE read, LSB first.
        dr_scan(32'h0, 32, got, pulse);
        check("idcode_tdo", got, 32'h1234_5A5B);
        check("idcode_ir_kept", 32'(irValue), 32'h1);
        check("idcode_no_pulse", 32'(pulse), 32'h0);

        // IR scan of all-ones: captured 0001 comes out; all-ones selects BYPASS.
        ir_scan(4'b1111, got_ir);
        check("ir_capture_tdo", 32'(got_ir), 32'h1);
        check("ir_all_ones", 32'(irValue), 32'hF);
        dr_scan(32'b101, 3, got, pulse);
        check("bypass_tdo", got, 32'b010);
        check("bypass_no_pulse", 32'(pulse), 32'h0);

        // Select USER and write A5.
        ir_scan(4'b0010, got_ir);
        check("ir_user", 32'(irValue), 32'h2);
        dr_scan(32'hA5, 8, got, pulse);
        check("user_first_tdo", got, 32'h00);
        check("user_pulse", 32'(pulse), 32'h1);
        check("user_pulse_gone", 32'(updateDrPulse), 32'h0);
        check("user_a5", 32'(userReg), 32'hA5);
        dr_scan(32'h3C, 8, got, pulse);
        check("user_readback_a5", got, 32'hA5);
        check("user_3c", 32'(userReg), 32'h3C);

        // USER scan of 5A with a 10-cycle PAUSE_DR between bit 3 and bit 4.
        got = '0;
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            got[i] = Tdo;
            step(i == 3, 1'(8'h5A >> i));
        end
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0);
        check("pause_state", 32'(tapState), 32'h3);
        check("pause_tdo", 32'(Tdo), 32'h0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        for (int i = 4; i < 8; i++) begin
            got[i] = Tdo;
            step(i == 7, 1'(8'h5A >> i));
        end
        check("pause_no_early_write", 32'(userReg), 32'h3C);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        check("pause_tdo_bits", got, 32'h3C);
        check("pause_user_5a", 32'(userReg), 32'h5A);

        // Reset during SHIFT_DR after 4 bits.
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1);
        check("pre_reset_shift", 32'(tapState), 32'h2);
        #2;
        reset = 1'b1;
        #1;
        check("abort_state", 32'(tapState), 32'hF);
        check("abort_user", 32'(userReg), 32'h0);
        check("abort_ir", 32'(irValue), 32'h1);
        check("abort_pulse", 32'(updateDrPulse), 32'h0);
        check("abort_tdo", 32'(Tdo), 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        step(1'b1, 1'b0);
        check("after_abort_state", 32'(tapState), 32'hF);
        check("after_abort_user", 32'(userReg), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
